// File: rtl/watchdog_window.sv
// watchdog_window: memory-mapped watchdog with kick, early-kick window, pre-timeout warning,
// sticky expiry status and a write-once configuration lock.
module watchdog_window #(
    parameter int          TIMER_WIDTH     = 28,
    parameter logic [31:0] DEFAULT_TIMEOUT = 32'h07ff_ffff,
    parameter logic [31:0] DEFAULT_WINDOW  = 32'hffff_ffff,
    parameter logic [31:0] DEFAULT_WARN    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        timeout,
    output logic        warn
);
    localparam int W = TIMER_WIDTH;
    typedef enum logic [1:0] {IDLE, RUNNING, EXPIRED} state_t;
    state_t         state_q;
    logic [W-1:0]   counter_q, init_q, window_q, warn_q;
    logic           lock_q, expired_q, early_q;
    logic [2:0]     cmd_q;
    logic           wr, cfg_ok, unused_wd;
    logic [W-1:0]   wdata;
    assign wr        = cs && we;
    assign cfg_ok    = wr && state_q == IDLE && !lock_q;
    assign wdata     = write_data[W-1:0];
    assign unused_wd = ^write_data;
    assign ready     = cs;
    assign timeout   = expired_q;
    assign warn      = state_q == RUNNING && warn_q != '0 && counter_q <= warn_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            counter_q <= '0;
            init_q    <= DEFAULT_TIMEOUT[W-1:0];
            window_q  <= DEFAULT_WINDOW[W-1:0];
            warn_q    <= DEFAULT_WARN[W-1:0];
            lock_q    <= 1'b0;
            expired_q <= 1'b0;
            early_q   <= 1'b0;
            cmd_q     <= 3'b0;
        end else begin
            cmd_q <= (wr && address == 8'h08) ? write_data[2:0] : 3'b0;
            if (cfg_ok && address == 8'h0a) init_q <= wdata;
            if (cfg_ok && address == 8'h0c) window_q <= wdata;
            if (cfg_ok && address == 8'h0d) warn_q <= wdata;
            if (wr && address == 8'h0e && write_data[0]) lock_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (cmd_q[0] && !cmd_q[1]) begin
                        state_q   <= RUNNING;
                        counter_q <= init_q;
                    end
                end
                RUNNING: begin
                    // expiry is tested before any command so a late kick cannot rescue a zero count
                    if (counter_q == '0) begin
                        state_q   <= EXPIRED;
                        expired_q <= 1'b1;
                    end else if (cmd_q[1] && !lock_q) begin
                        state_q <= IDLE;
                    end else if (cmd_q[2] && counter_q <= window_q) begin
                        counter_q <= init_q;
                    end else if (cmd_q[2]) begin
                        state_q   <= EXPIRED;
                        expired_q <= 1'b1;
                        early_q   <= 1'b1;
                        counter_q <= '0;
                    end else begin
                        counter_q <= counter_q - W'(1);
                    end
                end
                default: counter_q <= '0;
            endcase
        end
    end
    always_comb begin
        read_data = '0;
        if (cs)
            case (address)
                8'h09:   read_data = {27'b0, warn, lock_q, early_q, expired_q, state_q == RUNNING};
                8'h0a:   read_data = 32'(init_q);
                8'h0b:   read_data = 32'(counter_q);
                8'h0c:   read_data = 32'(window_q);
                8'h0d:   read_data = 32'(warn_q);
                8'h0e:   read_data = {31'b0, lock_q};
                default: read_data = '0;
            endcase
    end
endmodule

// File: tb/tb_watchdog_window.sv
// tb_watchdog_window: directed plus randomized bus traffic checked through a scoreboard
// against a deadline-based reference model of the watchdog.
module tb_watchdog_window;
    localparam int     TW   = 28;
    localparam longint MASK = (longint'(1) << TW) - 1;
    logic        clk = 1'b0;
    logic        reset, cs, we;
    logic [7:0]  address;
    logic [31:0] write_data, read_data, rd8, rd32;
    logic        ready, timeout, warn, rdy8, rdy32, to8, to32, wn8, wn32;
    always #5 clk = ~clk;
    watchdog_window #(.TIMER_WIDTH(TW)) dut (.clk(clk), .reset(reset), .cs(cs), .we(we), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready), .timeout(timeout), .warn(warn));
    watchdog_window #(.TIMER_WIDTH(8)) dut8 (.clk(clk), .reset(reset), .cs(cs), .we(we), .address(address),
        .write_data(write_data), .read_data(rd8), .ready(rdy8), .timeout(to8), .warn(wn8));
    watchdog_window #(.TIMER_WIDTH(32)) dut32 (.clk(clk), .reset(reset), .cs(cs), .we(we), .address(address),
        .write_data(write_data), .read_data(rd32), .ready(rdy32), .timeout(to32), .warn(wn32));
    typedef struct {
        bit          chk;
        bit          rd_chk;
        bit          p_chk;
        logic [31:0] rd;
        bit          to;
        bit          wr;
        bit          rdy;
    } exp_t;
    exp_t   sb[$];
    exp_t   mon_e;
    int     n_cmp = 0, n_bad = 0;
    // model: while running the counter is deadline - cycle, otherwise the held value
    longint cyc = 0, m_dl = 0, m_hold = 0, m_init = 0, m_win = 0, m_warn = 0;
    int     m_st = 0;
    bit     m_lock = 0, m_early = 0, m_ok = 0;
    bit [2:0] m_cmd = 0;
    logic [7:0] cfg [3] = '{8'h0a, 8'h0c, 8'h0d};
    function automatic longint cnt();
        return m_st == 1 ? m_dl - cyc : m_hold;
    endfunction
    function automatic bit exp_warn();
        return m_st == 1 && m_warn != 0 && cnt() <= m_warn;
    endfunction
    function automatic logic [31:0] rd_exp(input logic [7:0] a);
        case (a)
            8'h09:   return {27'b0, exp_warn(), m_lock, m_early, m_st == 2, m_st == 1};
            8'h0a:   return 32'(m_init);
            8'h0b:   return 32'(cnt());
            8'h0c:   return 32'(m_win);
            8'h0d:   return 32'(m_warn);
            8'h0e:   return {31'b0, m_lock};
            default: return 32'h0;
        endcase
    endfunction
    task automatic adv(input bit r, input bit c, input bit w, input logic [7:0] a, input logic [31:0] d);
        longint v = cnt();
        bit idle = m_st == 0;
        bit lk = m_lock;
        if (r) begin
            m_st = 0; m_hold = 0; m_init = 64'h07ff_ffff & MASK; m_win = MASK; m_warn = 0;
            m_lock = 0; m_early = 0; m_cmd = 0; m_ok = 1;
        end else begin
            if (m_st == 1) begin
                if (v == 0) begin
                    m_st = 2; m_hold = 0;
                end else if (m_cmd[1] && !lk) begin
                    m_st = 0; m_hold = v;
                end else if (m_cmd[2]) begin
                    if (v <= m_win) m_dl = cyc + 1 + m_init;
                    else begin m_st = 2; m_early = 1; m_hold = 0; end
                end
            end else if (idle && m_cmd[0] && !m_cmd[1]) begin
                m_st = 1; m_dl = cyc + 1 + m_init;
            end
            m_cmd = (c && w && a == 8'h08) ? d[2:0] : 3'b0;
            if (c && w && idle && !lk) begin
                if (a == 8'h0a) m_init = longint'(d) & MASK;
                if (a == 8'h0c) m_win = longint'(d) & MASK;
                if (a == 8'h0d) m_warn = longint'(d) & MASK;
            end
            if (c && w && a == 8'h0e && d[0]) m_lock = 1;
        end
        cyc++;
    endtask
    task automatic op(input bit r, input bit c, input bit w, input logic [7:0] a, input logic [31:0] d,
                      input bit p = 0);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r; cs = c; we = w; address = a; write_data = d;
        e.chk = m_ok; e.to = m_st == 2; e.wr = exp_warn(); e.rdy = c; e.p_chk = p;
        e.rd_chk = !(c && w);
        e.rd = (c && !w) ? rd_exp(a) : 32'h0;
        sb.push_back(e);
        adv(r, c, w, a, d);
    endtask
    task automatic wr(input logic [7:0] a, input logic [31:0] d); op(0, 1, 1, a, d); endtask
    task automatic rd(input logic [7:0] a, input bit p = 0); op(0, 1, 0, a, 32'h0, p); endtask
    task automatic rst(); op(1, 0, 0, 8'h00, 32'h0); endtask
    task automatic reads(input int n);
        for (int i = 0; i < n; i++) rd(i % 2 ? 8'h09 : 8'h0b);
    endtask
    task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %h, expected %h", n, $time, act, exp);
        end
    endtask
    initial forever begin
        @(negedge clk);
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            if (mon_e.chk) begin
                cmp("timeout", 32'(timeout), 32'(mon_e.to));
                cmp("warn", 32'(warn), 32'(mon_e.wr));
                cmp("ready", 32'(ready), 32'(mon_e.rdy));
                if (mon_e.rd_chk) cmp($sformatf("read_data@%02h", address), read_data, mon_e.rd);
                if (mon_e.p_chk) begin
                    cmp("init_w8", rd8, 32'h0000_00ff);
                    cmp("init_w32", rd32, 32'hffff_ffff);
                end
            end
        end
    end
    initial begin
        int r;
        rst();
        rd(8'h09); rd(8'h0a); rd(8'h0b); rd(8'h0c); rd(8'h0d); rd(8'h0e);
        wr(8'h0a, 32'hffff_ffff); rd(8'h0a, 1);
        wr(8'h0a, 10); wr(8'h08, 1); reads(16); wr(8'h08, 4); wr(8'h08, 1); wr(8'h0a, 3); reads(4); rd(8'h0a); rst();
        wr(8'h0a, 100); wr(8'h0c, 40); wr(8'h08, 1); reads(70); wr(8'h08, 4); reads(45); wr(8'h08, 4); reads(4); rst();
        wr(8'h0a, 50); wr(8'h0d, 20); wr(8'h08, 1); reads(36); wr(8'h08, 4); reads(6); rst();
        wr(8'h0a, 30); wr(8'h08, 1); reads(3); wr(8'h0e, 1); wr(8'h08, 2); reads(4);
        wr(8'h0a, 5); rd(8'h0a); rst(); rd(8'h0e); rd(8'h0a);
        wr(8'h0a, 3); wr(8'h08, 1); reads(3); wr(8'h08, 4); reads(3); rst();
        wr(8'h08, 3); reads(4);
        wr(8'h0a, 0); wr(8'h08, 1); reads(4); rst();
        wr(8'h0a, 20); wr(8'h08, 1); reads(5); rst(); reads(3);
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) rst();
            else if (r < 16) wr(8'h08, $urandom_range(0, 7));
            else if (r < 24) wr(cfg[$urandom_range(0, 2)], $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 60));
            else if (r < 25) wr(8'h0e, $urandom_range(0, 1));
            else if (r < 28) wr(8'($urandom_range(0, 255)), $urandom);
            else if (r < 38) op(0, 0, $urandom_range(0, 1), 8'($urandom_range(0, 255)), $urandom);
            else rd($urandom_range(0, 3) == 0 ? 8'($urandom_range(0, 255)) : 8'($urandom_range(8, 15)));
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/watchdog_window.md
Name: watchdog_window

Overview:
- Next-generation watchdog core with its bus wrapper, parametrised in timer width.
- Adds over the current watchdog: an explicit kick (reload) command, a windowed mode that flags early kicks, a pre-timeout warning output, sticky expiry status, and a write-once lock.
- Sits on the application FPGA core bus as a memory-mapped peripheral; `timeout` feeds the system reset/fault logic and `warn` feeds the interrupt logic.

Parameters:
- TIMER_WIDTH, 28: width of counter, init, window and warn registers (legal 8..32).
- DEFAULT_TIMEOUT, 28'h7ff_ffff: reset value of timer_init.
- DEFAULT_WINDOW, all ones: reset value of window; all ones disables the window check.
- DEFAULT_WARN, 0: reset value of warn threshold; 0 disables the warning.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous reset, active-high.
- cs  in  1  bus chip select.
- we  in  1  write enable, qualified by cs.
- address  in  8  register address.
- write_data  in  32  write data.
- read_data  out  32  read data, combinational; 0 when cs=0 or on unmapped reads.
- ready  out  1  equals cs (zero wait states).
- timeout  out  1  sticky expiry flag; cleared only by reset.
- warn  out  1  high while RUNNING and counter <= warn_reg, with warn_reg != 0.

Behaviour:
- Reset values:
  - timeout=0, warn=0, read_data=0, state=IDLE, counter=0, lock=0, status bits 0.
  - timer_init=DEFAULT_TIMEOUT, window=DEFAULT_WINDOW, warn_reg=DEFAULT_WARN.
- Register map (write / read):
  - 0x08 CTRL W: bit0 start, bit1 stop, bit2 kick. Single-cycle command pulses, registered one cycle before acting.
  - 0x09 STATUS R: bit0 running, bit1 expired, bit2 early_kick, bit3 locked, bit4 warn.
  - 0x0a TIMER_INIT R/W.
  - 0x0b CURR_TIMER R.
  - 0x0c WINDOW R/W.
  - 0x0d WARN R/W.
  - 0x0e LOCK: W bit0=1 sets lock; R bit0.
  - Registers narrower than 32 bits use write_data[TIMER_WIDTH-1:0]; reads are zero-extended.
- Config write rules: writes to TIMER_INIT, WINDOW and WARN are ignored when state != IDLE or lock=1. Lock can only be cleared by reset.
- Command latency: a CTRL write in cycle N is registered at the end of N and takes effect at the end of N+1, so the effect is visible from cycle N+2.
- FSM, state IDLE:
  - start -> RUNNING; counter loaded with timer_init.
  - stop and kick ignored.
- FSM, state RUNNING, priority order each cycle:
  1. counter==0 -> EXPIRED; timeout=1, expired=1. Expiry beats any concurrent command.
  2. stop with lock=0 -> IDLE; counter holds its value. Stop is ignored when locked.
  3. kick:
     - counter <= window -> counter reloaded with timer_init.
     - counter > window -> EXPIRED; timeout=1, expired=1, early_kick=1.
  4. Otherwise counter decrements by 1. No wrap: it is tested at 0 before decrementing.
  - start while RUNNING is ignored.
  - start and stop in the same write: stop wins in RUNNING; nothing happens in IDLE.
- FSM, state EXPIRED: terminal until reset. All commands ignored; running=0, counter holds 0.
- Expiry timing: start written in cycle N with timer_init=T:
  - CURR_TIMER reads T in cycle N+2 and T-k in cycle N+2+k.
  - timeout rises in cycle N+3+T.
  - T=0 gives expiry visible in cycle N+3.
- Derived outputs: warn is combinational from state, counter and warn_reg; it drops on kick reload or on leaving RUNNING.
- Reset in any state, including mid-count or EXPIRED, restores every reset value in the next cycle.

Test Plan:
- Basic expiry: timer_init=10, start at cycle N -> CURR_TIMER=10 at N+2, 0 at N+12; timeout=1 and STATUS=0x2 from N+13; further writes have no effect until reset.
- Kick inside window: init=100, window=40. Kick while counter=30 -> counter=100 two cycles after the write; no timeout. Kick while counter=60 -> timeout=1 and STATUS bits1,2 set.
- Warning: init=50, warn=20 -> warn rises the cycle the counter equals 20. Kick at counter=15 (window all ones) -> warn falls with the reload.
- Lock: while RUNNING, write LOCK=1 then CTRL stop -> still running. Write TIMER_INIT=5 -> readback unchanged. Reset -> lock=0, timer_init=DEFAULT_TIMEOUT.
- Boundaries:
  - Kick landing in the cycle counter==0 -> expiry wins.
  - start+stop in one write while IDLE -> stays IDLE.
  - init=0 -> timeout at N+3.
  - Reset asserted mid-count -> next cycle all outputs 0 and state IDLE.
- Parametrisation: run the suite with TIMER_WIDTH=8 and 32. Write 0xFFFF_FFFF to TIMER_INIT -> readback equals 0xFF and 0xFFFF_FFFF respectively.
